calc_unit: RTL and testbench

- Parametrised, handshaked successor to the single-width calculator core.
- Accepts one operation at a time on a valid/ready input channel and computes ADD/SUB/logic ops in one cycle.
- MUL uses an iterative shift-add datapath, WIDTH cycles long.
- Keeps an internal accumulator that can replace operand A, and returns a 2*WIDTH result plus flags on a valid/ready output channel.

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_mul_seq.sv | 51 +++++
 rtl/calc_unit.sv | 151 +++++++++++++++
 tb/tb_calc_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcodes, FSM encoding and flag bundle
// for the handshaked calculator unit.
package calc_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd2;
  localparam logic [OP_W-1:0] OP_AND  = 3'd3;
  localparam logic [OP_W-1:0] OP_OR   = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_CLR  = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic err;
  } flags_t;

endpackage

// File: rtl/calc_mul_seq.sv
// Iterative unsigned shift-add multiplier.
// done pulses WIDTH cycles after start.
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // The start edge already folds in bit 0, so
  // WIDTH-1 further steps remain afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= {{WIDTH{1'b0}}, a} << 1;
        mplier  <= b >> 1;
        cnt     <= CW'(WIDTH - 1);
        product <= b[0] ? {{WIDTH{1'b0}}, a}
                        : '0;
      end else if (cnt != '0) begin
        if (mplier[0])
          product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        done   <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/calc_unit.sv
// Handshaked calculator: 1-cycle ALU, iterative MUL,
// accumulator and registered result/flags.
module calc_unit
  import calc_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic               use_acc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               zero,
  output logic               err,
  output logic [WIDTH-1:0]   acc
);

  localparam int RW = 2 * WIDTH;

  state_t state, state_nxt;

  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [RW-1:0]    mul_prod;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] alu_acc;
  logic             alu_acc_wr;
  flags_t           alu_flags;
  flags_t           mul_flags;
  flags_t           flags_q;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL);
  assign a_eff     = use_acc ? acc : a;

  assign sum  = {1'b0, a_eff} + {1'b0, b};
  assign diff = {1'b0, a_eff} - {1'b0, b};

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (a_eff),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (accept)
          state_nxt = is_mul ? ST_MUL : ST_DONE;
      ST_MUL:
        if (mul_done) state_nxt = ST_DONE;
      ST_DONE:
        if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_res    = '0;
    alu_flags  = '0;
    alu_acc_wr = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        alu_res            = sum[WIDTH-1:0];
        alu_flags.carry    = sum[WIDTH];
        alu_flags.overflow =
          (a_eff[WIDTH-1] == b[WIDTH-1]) &&
          (sum[WIDTH-1] != a_eff[WIDTH-1]);
        alu_acc_wr         = 1'b1;
      end
      (op == OP_SUB): begin
        alu_res            = diff[WIDTH-1:0];
        alu_flags.carry    = diff[WIDTH];
        alu_flags.overflow =
          (a_eff[WIDTH-1] != b[WIDTH-1]) &&
          (diff[WIDTH-1] != a_eff[WIDTH-1]);
        alu_acc_wr         = 1'b1;
      end
      (op == OP_AND): begin
        alu_res    = a_eff & b;
        alu_acc_wr = 1'b1;
      end
      (op == OP_OR): begin
        alu_res    = a_eff | b;
        alu_acc_wr = 1'b1;
      end
      (op == OP_XOR): begin
        alu_res    = a_eff ^ b;
        alu_acc_wr = 1'b1;
      end
      (op == OP_CLR): alu_acc_wr = 1'b1;
      (op == OP_RSVD): alu_flags.err = 1'b1;
      default: ;
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_acc = (op == OP_CLR) ? ACC_INIT : alu_res;
  end

  always_comb begin
    mul_flags          = '0;
    mul_flags.overflow = |mul_prod[RW-1:WIDTH];
    mul_flags.zero     = (mul_prod == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result  <= '0;
      flags_q <= '0;
      acc     <= ACC_INIT;
    end else if (accept && !is_mul) begin
      result  <= {{WIDTH{1'b0}}, alu_res};
      flags_q <= alu_flags;
      if (alu_acc_wr) acc <= alu_acc;
    end else if (state == ST_MUL && mul_done) begin
      result  <= mul_prod;
      flags_q <= mul_flags;
      acc     <= mul_prod[WIDTH-1:0];
    end
  end

  assign carry    = flags_q.carry;
  assign overflow = flags_q.overflow;
  assign zero     = flags_q.zero;
  assign err      = flags_q.err;

endmodule

// File: tb/tb_calc_unit.sv
// Directed plus randomized checks of calc_unit
// against an arithmetic reference model.
module tb_calc_unit;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = '0;
  logic            use_acc = 1'b0;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*W-1:0]  result;
  logic            carry;
  logic            overflow;
  logic            zero;
  logic            err;
  logic [W-1:0]    acc;

  int total = 0;
  int bad   = 0;
  int m_acc = 0;

  calc_unit #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .use_acc   (use_acc),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .err       (err),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= M / 2) ? v - M : v;
  endfunction

  // Reference: plain integer arithmetic on A, B.
  task automatic model(input int o, input int av,
                       input int bv, output int res,
                       output int c, output int v,
                       output int e);
    int t;
    res = 0; c = 0; v = 0; e = 0;
    case (o)
      0: begin
        t = av + bv;
        res = t % M;
        c = (t >= M);
        t = sgn(av) + sgn(bv);
        v = (t >= M / 2) || (t < -M / 2);
        m_acc = res;
      end
      1: begin
        res = (av - bv + M) % M;
        c = (av < bv);
        t = sgn(av) - sgn(bv);
        v = (t >= M / 2) || (t < -M / 2);
        m_acc = res;
      end
      2: begin
        res = av * bv;
        v = (res >= M);
        m_acc = res % M;
      end
      3: begin res = av & bv; m_acc = res; end
      4: begin res = av | bv; m_acc = res; end
      5: begin res = av ^ bv; m_acc = res; end
      6: begin res = 0; m_acc = 0; end
      default: e = 1;
    endcase
  endtask

  task automatic run_op(input int o, input int ua,
                        input int av, input int bv,
                        input int hold, input int junk);
    int ea, res, c, v, e, lat;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    ea = ua ? m_acc : av;
    model(o, ea, bv, res, c, v, e);
    op = 3'(o);
    use_acc = ua[0];
    a = W'(av);
    b = W'(bv);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      chk("in_ready_busy", 32'(in_ready), 0);
      if (junk != 0) begin
        in_valid = 1'b1;
        op = 3'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        use_acc = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, (o == 2) ? W + 1 : 1);
    chk("result", 32'(result), res);
    chk("carry", 32'(carry), c);
    chk("overflow", 32'(overflow), v);
    chk("zero", 32'(zero), (res == 0));
    chk("err", 32'(err), e);
    chk("acc", 32'(acc), m_acc);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ready", 32'(in_ready), 0);
      chk("hold_result", 32'(result), res);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_result", 32'(result), 0);
    chk("rst_acc", 32'(acc), 0);
    reset = 1'b1;

    run_op(0, 0, 200, 100, 0, 0);
    chk("t1_res", 32'(result), 32'h002C);
    chk("t1_carry", 32'(carry), 1);

    run_op(1, 0, 5, 7, 0, 0);
    chk("t2a_res", 32'(result), 32'h00FE);
    run_op(1, 0, 8'h80, 8'h01, 0, 0);
    chk("t2b_ovf", 32'(overflow), 1);
    chk("t2b_carry", 32'(carry), 0);

    run_op(2, 0, 255, 255, 0, 1);
    chk("t3_res", 32'(result), 32'hFE01);
    chk("t3_ovf", 32'(overflow), 1);

    run_op(6, 0, 0, 0, 0, 0);
    chk("t4_clr_zero", 32'(zero), 1);
    run_op(0, 1, 0, 3, 0, 0);
    chk("t4_r3", 32'(result), 3);
    run_op(0, 1, 0, 3, 0, 0);
    chk("t4_r6", 32'(result), 6);
    run_op(0, 1, 0, 3, 0, 0);
    chk("t4_r9", 32'(result), 9);
    chk("t4_acc9", 32'(acc), 9);
    run_op(2, 1, 0, 0, 0, 0);
    chk("t4_mul0", 32'(result), 0);
    chk("t4_acc0", 32'(acc), 0);

    run_op(5, 0, 8'hF0, 8'hFF, 5, 0);
    chk("t5_xor", 32'(result), 32'h000F);
    run_op(7, 0, 8'h12, 8'h34, 0, 0);
    chk("t5_err", 32'(err), 1);
    chk("t5_acc", 32'(acc), 32'h0F);

    // Reset mid-MUL
    @(negedge clk);
    op = 3'd2; a = 8'd13; b = 8'd11;
    use_acc = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_result", 32'(result), 0);
    chk("t6_flags",
        32'({carry, overflow, zero, err}), 0);
    chk("t6_acc", 32'(acc), 0);
    chk("t6_ready", 32'(in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    m_acc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t6_abort", 32'(out_valid), 0);
    end
    run_op(0, 0, 1, 1, 0, 0);
    chk("t6_add", 32'(result), 2);

    for (int i = 0; i < 40; i++)
      run_op($urandom_range(7, 0),
             $urandom_range(1, 0),
             $urandom_range(M - 1, 0),
             $urandom_range(M - 1, 0),
             $urandom_range(3, 0), 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
